link_hang_monitor: RTL

Receiver-side watchdog for one credit-based NoC link port. It passes flits from the link to the local router input unchanged, and counts how long an open packet sits with the receiver ready but no flit arriving. A stall of TIMEOUT cycles is declared a hang: the block reports it and, optionally, closes the broken packet downstream and discards the late remainder upstream. It is the detection and countermeasure end of the link-hang fault, and sits between the link wires and the router input buffer.

---
 rtl/link_mon_pkg.sv | 20 ++
 rtl/link_stall_timer.sv | 44 ++++
 rtl/link_hang_monitor.sv | 112 +++++++++++
 3 files changed

// File: rtl/link_mon_pkg.sv
// Shared types and constants for the link hang monitor.
package link_mon_pkg;

    // Monitor FSM states; FLUSH and DISCARD are only reachable with HANG_FLUSH_EN.
    typedef enum logic [2:0] {
        IDLE,
        IN_PKT,
        HUNG,
        FLUSH,
        DISCARD
    } lmon_fsm_t;

    // Router port indices.
    localparam int unsigned EAST  = 0;
    localparam int unsigned WEST  = 1;
    localparam int unsigned NORTH = 2;
    localparam int unsigned SOUTH = 3;
    localparam int unsigned LOCAL = 4;

endpackage

// File: rtl/link_stall_timer.sv
// Stall counter for the link hang monitor: counts increment requests up to
// TIMEOUT, then reports expiry as a one-cycle registered pulse and restarts.
module link_stall_timer #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic hold,
    input  logic incr,
    output logic at_limit,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    assign at_limit = (count == LIMIT);

    // Counter with priority clear > hold > increment; wraps to zero on expiry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count  <= '0;
            expire <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (clear) begin
                count <= '0;
            end else if (hold) begin
                count <= count;
            end else if (incr) begin
                if (at_limit) begin
                    count  <= '0;
                    expire <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/link_hang_monitor.sv
// Receiver-side link hang watchdog. Passes flits through with zero latency and
// reports packets that stall for TIMEOUT ready cycles.
// Define HANG_FLUSH_EN to compile in the flush/discard recovery path.
module link_hang_monitor
    import link_mon_pkg::*;
#(
    parameter logic [15:0]        ADDRESS    = 16'h0000,
    parameter int unsigned        PORT_ID    = EAST,
    parameter int unsigned        FLIT_W     = 32,
    parameter int unsigned        TIMEOUT    = 256,
    parameter logic [FLIT_W-1:0]  FLUSH_FLIT = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    input  logic              eop_rx_i,
    input  logic [FLIT_W-1:0] data_i,
    output logic              cr_rx_o,
    output logic              rx_o,
    output logic              eop_o,
    output logic [FLIT_W-1:0] data_o,
    input  logic              cr_i,
    output logic              hang_o,
    output logic [7:0]        hang_cnt_o,
    output logic              in_pkt_o
);

    lmon_fsm_t state, next;
    logic      hs;
    logic      stall;
    logic      at_limit;
    logic      expire;

    assign hs    = rx_i && cr_i;
    assign stall = (state == IN_PKT) && !rx_i && cr_i;

    // The timer only runs inside an open packet; any handshake restarts it.
    link_stall_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear   (hs || (state != IN_PKT)),
        .hold    (!cr_i),
        .incr    ((state == IN_PKT) && !rx_i),
        .at_limit(at_limit),
        .expire  (expire)
    );

    assign hang_o   = expire;
    assign in_pkt_o = (state != IDLE);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Next-state and output muxing; passthrough unless recovering.
    always_comb begin
        next    = state;
        rx_o    = rx_i;
        eop_o   = eop_rx_i;
        data_o  = data_i;
        cr_rx_o = cr_i;
        case (state)
            IDLE: begin
                if (hs && !eop_rx_i) next = IN_PKT;
            end
            IN_PKT: begin
                if (hs && eop_rx_i)        next = IDLE;
                else if (stall && at_limit) next = HUNG;
            end
            HUNG: begin
`ifdef HANG_FLUSH_EN
                next = FLUSH;
`else
                if (hs) next = eop_rx_i ? IDLE : IN_PKT;
`endif
            end
`ifdef HANG_FLUSH_EN
            FLUSH: begin
                rx_o    = 1'b1;
                eop_o   = 1'b1;
                data_o  = FLUSH_FLIT;
                cr_rx_o = 1'b0;
                if (cr_i) next = DISCARD;
            end
            DISCARD: begin
                rx_o    = 1'b0;
                eop_o   = 1'b0;
                cr_rx_o = 1'b1;
                if (rx_i && eop_rx_i) next = IDLE;
            end
`endif
            default: next = IDLE;
        endcase
    end

    // Saturating count of hang detections.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hang_cnt_o <= '0;
        end else if ((state != HUNG) && (next == HUNG) && (hang_cnt_o != 8'hFF)) begin
            hang_cnt_o <= hang_cnt_o + 8'd1;
        end
    end

endmodule
